// File: rtl/em_pipe_stage_reg_pkg.sv
// Shared MIPS definitions for the EX->MEM pipeline register: field widths,
// the NOP encoding and the exception codes carried down the pipe.
package em_pipe_stage_reg_pkg;
    localparam int          REG_W      = 5;
    localparam int          EXC_W      = 5;
    localparam int          TNEW_W_DEF = 2;
    localparam logic [31:0] NOP_INSTR  = 32'h0;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;
endpackage

// File: rtl/em_pipe_stage_reg_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; holds when inc=0.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/em_pipe_stage_reg.sv
// EX->MEM pipeline register: stall/flush control, Tnew ageing, $0 write
// suppression and saturating counts of instructions and bubbles passed to M.
module em_pipe_stage_reg
    import em_pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W           = 32,
    parameter int                TNEW_W           = TNEW_W_DEF,
    parameter logic [DATA_W-1:0] RESET_PC         = 32'h0000_3000,
    parameter bit                KEEP_PC_ON_FLUSH = 1'b1,
    parameter int                PERF_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic              valid_E,
    input  logic [DATA_W-1:0] pc_E,
    input  logic [DATA_W-1:0] instr_E,
    input  logic [DATA_W-1:0] ALUOut_E,
    input  logic [DATA_W-1:0] WriteData_E,
    input  logic [REG_W-1:0]  A3_E,
    input  logic              RegWrite_E,
    input  logic [TNEW_W-1:0] Tnew_E,
    input  logic [EXC_W-1:0]  ExcCode_E,
    input  logic              BD_E,
    output logic              valid_M,
    output logic [DATA_W-1:0] pc_M,
    output logic [DATA_W-1:0] instr_M,
    output logic [DATA_W-1:0] ALUOut_M,
    output logic [DATA_W-1:0] WriteData_M,
    output logic [REG_W-1:0]  A3_M,
    output logic              RegWrite_M,
    output logic [TNEW_W-1:0] Tnew_M,
    output logic [EXC_W-1:0]  ExcCode_M,
    output logic              BD_M,
    output logic [PERF_W-1:0] inst_cnt,
    output logic [PERF_W-1:0] bubble_cnt
);
    logic              w_adv;
    logic              w_bubble;
    logic              w_real;
    logic              w_wr_vis;
    logic [TNEW_W-1:0] w_tnew_aged;

    assign w_adv       = en | flush;
    assign w_bubble    = flush | ~valid_E;
    assign w_real      = w_adv & ~w_bubble;
    // Writes to $0 are hidden from the hazard unit entirely.
    assign w_wr_vis    = RegWrite_E & (A3_E != '0);
    assign w_tnew_aged = (Tnew_E == '0) ? '0 : Tnew_E - TNEW_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_M     <= 1'b0;
            pc_M        <= RESET_PC;
            instr_M     <= '0;
            ALUOut_M    <= '0;
            WriteData_M <= '0;
            A3_M        <= '0;
            RegWrite_M  <= 1'b0;
            Tnew_M      <= '0;
            ExcCode_M   <= '0;
            BD_M        <= 1'b0;
        end else if (w_adv) begin
            if (w_bubble) begin
                valid_M     <= 1'b0;
                pc_M        <= KEEP_PC_ON_FLUSH ? pc_E : '0;
                instr_M     <= DATA_W'(NOP_INSTR);
                ALUOut_M    <= '0;
                WriteData_M <= '0;
                A3_M        <= '0;
                RegWrite_M  <= 1'b0;
                Tnew_M      <= '0;
                ExcCode_M   <= EXC_NONE;
                BD_M        <= KEEP_PC_ON_FLUSH ? BD_E : 1'b0;
            end else begin
                valid_M     <= 1'b1;
                pc_M        <= pc_E;
                instr_M     <= instr_E;
                ALUOut_M    <= ALUOut_E;
                WriteData_M <= WriteData_E;
                A3_M        <= w_wr_vis ? A3_E : '0;
                RegWrite_M  <= w_wr_vis;
                Tnew_M      <= w_wr_vis ? w_tnew_aged : '0;
                ExcCode_M   <= ExcCode_E;
                BD_M        <= BD_E;
            end
        end
    end

    sat_counter #(.W(PERF_W)) u_inst_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_real),
        .cnt   (inst_cnt)
    );

    sat_counter #(.W(PERF_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_adv & w_bubble),
        .cnt   (bubble_cnt)
    );
endmodule

// File: tb/tb_em_pipe_stage_reg.sv
// Scoreboard bench: three builds (default, no-pc-keep, 4-bit counters) share
// stimulus; expected bundles are queued at drive time and checked by a monitor.
module tb_em_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        reset, en, flush, valid_E, RegWrite_E, BD_E;
    logic [31:0] pc_E, instr_E, ALUOut_E, WriteData_E;
    logic [4:0]  A3_E, ExcCode_E;
    logic [1:0]  Tnew_E;

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc, instr, alu, wd;
        logic [4:0]  a3;
        logic        rw;
        logic [1:0]  tnew;
        logic [4:0]  exc;
        logic        bd;
        logic [15:0] ic, bc;
    } out_t;

    logic        v_M[3], rw_M[3], bd_M[3];
    logic [31:0] pc_M[3], instr_M[3], alu_M[3], wd_M[3];
    logic [4:0]  a3_M[3], exc_M[3];
    logic [1:0]  tnew_M[3];
    logic [15:0] ic0, bc0, ic1, bc1;
    logic [3:0]  ic2, bc2;

    em_pipe_stage_reg u_dut0 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_E(valid_E),
        .pc_E(pc_E), .instr_E(instr_E), .ALUOut_E(ALUOut_E), .WriteData_E(WriteData_E),
        .A3_E(A3_E), .RegWrite_E(RegWrite_E), .Tnew_E(Tnew_E), .ExcCode_E(ExcCode_E), .BD_E(BD_E),
        .valid_M(v_M[0]), .pc_M(pc_M[0]), .instr_M(instr_M[0]), .ALUOut_M(alu_M[0]),
        .WriteData_M(wd_M[0]), .A3_M(a3_M[0]), .RegWrite_M(rw_M[0]), .Tnew_M(tnew_M[0]),
        .ExcCode_M(exc_M[0]), .BD_M(bd_M[0]), .inst_cnt(ic0), .bubble_cnt(bc0));

    em_pipe_stage_reg #(.KEEP_PC_ON_FLUSH(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_E(valid_E),
        .pc_E(pc_E), .instr_E(instr_E), .ALUOut_E(ALUOut_E), .WriteData_E(WriteData_E),
        .A3_E(A3_E), .RegWrite_E(RegWrite_E), .Tnew_E(Tnew_E), .ExcCode_E(ExcCode_E), .BD_E(BD_E),
        .valid_M(v_M[1]), .pc_M(pc_M[1]), .instr_M(instr_M[1]), .ALUOut_M(alu_M[1]),
        .WriteData_M(wd_M[1]), .A3_M(a3_M[1]), .RegWrite_M(rw_M[1]), .Tnew_M(tnew_M[1]),
        .ExcCode_M(exc_M[1]), .BD_M(bd_M[1]), .inst_cnt(ic1), .bubble_cnt(bc1));

    em_pipe_stage_reg #(.PERF_W(4)) u_dut2 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_E(valid_E),
        .pc_E(pc_E), .instr_E(instr_E), .ALUOut_E(ALUOut_E), .WriteData_E(WriteData_E),
        .A3_E(A3_E), .RegWrite_E(RegWrite_E), .Tnew_E(Tnew_E), .ExcCode_E(ExcCode_E), .BD_E(BD_E),
        .valid_M(v_M[2]), .pc_M(pc_M[2]), .instr_M(instr_M[2]), .ALUOut_M(alu_M[2]),
        .WriteData_M(wd_M[2]), .A3_M(a3_M[2]), .RegWrite_M(rw_M[2]), .Tnew_M(tnew_M[2]),
        .ExcCode_M(exc_M[2]), .BD_M(bd_M[2]), .inst_cnt(ic2), .bubble_cnt(bc2));

    out_t  exp_q[$];
    int    sel_q[$];
    string nm_q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    event  sample_ev;

    function automatic out_t mk(logic v, logic [31:0] pc, logic [31:0] instr, logic [31:0] alu,
                                logic [31:0] wd, logic [4:0] a3, logic rw, logic [1:0] tnew,
                                logic [4:0] exc, logic bd, logic [15:0] ic, logic [15:0] bc);
        out_t o;
        o = '{v, pc, instr, alu, wd, a3, rw, tnew, exc, bd, ic, bc};
        return o;
    endfunction

    function automatic out_t act(int s);
        logic [15:0] ic, bc;
        ic = (s == 0) ? ic0 : (s == 1) ? ic1 : {12'h0, ic2};
        bc = (s == 0) ? bc0 : (s == 1) ? bc1 : {12'h0, bc2};
        return mk(v_M[s], pc_M[s], instr_M[s], alu_M[s], wd_M[s], a3_M[s], rw_M[s],
                  tnew_M[s], exc_M[s], bd_M[s], ic, bc);
    endfunction

    task automatic expect_out(string nm, int s, out_t e);
        exp_q.push_back(e);
        sel_q.push_back(s);
        nm_q.push_back(nm);
    endtask

    task automatic drv(logic e, logic f, logic v, logic [31:0] pc, logic [31:0] instr,
                       logic [31:0] alu, logic [31:0] wd, logic [4:0] a3, logic rw,
                       logic [1:0] tnew, logic [4:0] exc, logic bd);
        en = e; flush = f; valid_E = v; pc_E = pc; instr_E = instr; ALUOut_E = alu;
        WriteData_E = wd; A3_E = a3; RegWrite_E = rw; Tnew_E = tnew; ExcCode_E = exc; BD_E = bd;
    endtask

    // Monitor: after each rising edge (or an async-reset sample request) check everything queued.
    initial begin
        forever begin
            @(posedge clk or sample_ev);
            #1;
            while (exp_q.size() > 0) begin
                out_t  e, a;
                int    s;
                string nm;
                e = exp_q.pop_front(); s = sel_q.pop_front(); nm = nm_q.pop_front();
                a = act(s);
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s dut%0d got=%h expected=%h", nm, s, a, e);
                end
            end
        end
    end

    localparam logic [31:0] RPC = 32'h0000_3000;

    initial begin
        out_t rst_o, hold_o;
        rst_o = mk(0, RPC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        expect_out("reset_state", 0, rst_o);
        expect_out("reset_state", 1, rst_o);
        expect_out("reset_state", 2, rst_o);
        @(negedge clk);
        reset = 1'b1;
        expect_out("idle_after_reset", 0, rst_o);

        @(negedge clk);
        drv(1, 0, 1, 32'h3004, 32'h1234_5678, 32'h10, 32'h55, 5'd8, 1, 2'd2, 0, 0);
        expect_out("load", 0, mk(1, 32'h3004, 32'h1234_5678, 32'h10, 32'h55, 8, 1, 1, 0, 0, 1, 0));
        @(negedge clk);
        drv(1, 0, 1, 32'h3008, 32'h2, 32'h20, 32'h0, 5'd9, 1, 2'd0, 0, 1);
        expect_out("tnew_zero", 0, mk(1, 32'h3008, 32'h2, 32'h20, 0, 9, 1, 0, 0, 1, 2, 0));
        @(negedge clk);
        drv(1, 0, 1, 32'h300c, 32'h3, 32'h30, 32'h7, 5'd0, 1, 2'd2, 0, 0);
        expect_out("a3_zero", 0, mk(1, 32'h300c, 32'h3, 32'h30, 32'h7, 0, 0, 0, 0, 0, 3, 0));
        @(negedge clk);
        drv(1, 0, 1, 32'h3010, 32'h4, 32'h40, 32'h8, 5'd5, 0, 2'd3, 0, 0);
        expect_out("regwrite_zero", 0, mk(1, 32'h3010, 32'h4, 32'h40, 32'h8, 0, 0, 0, 0, 0, 4, 0));
        @(negedge clk);
        drv(1, 0, 1, 32'h3014, 32'h5, 32'h50, 32'h9, 5'd4, 1, 2'd3, 5'd4, 1);
        hold_o = mk(1, 32'h3014, 32'h5, 32'h50, 32'h9, 4, 1, 2, 4, 1, 5, 0);
        expect_out("exc_bd_load", 0, hold_o);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drv(0, 0, 1, 32'h3ff0 + k, 32'hdead_0000 + k, 32'hff, 32'hee, 5'd7, 1, 2'd1, 5'd12, 0);
            expect_out("stall_hold", 0, hold_o);
        end
        @(negedge clk);
        drv(0, 1, 1, 32'h3010, 32'haaaa_5555, 32'h77, 32'h66, 5'd3, 1, 2'd2, 5'd10, 1);
        expect_out("flush_no_en", 0, mk(0, 32'h3010, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1));
        @(negedge clk);
        drv(1, 0, 0, 32'h3020, 32'h9, 32'h99, 32'h88, 5'd6, 1, 2'd2, 5'd4, 0);
        expect_out("invalid_bubble", 0, mk(0, 32'h3020, 0, 0, 0, 0, 0, 0, 0, 0, 5, 2));
        @(negedge clk);
        drv(1, 1, 1, 32'h3024, 32'hb, 32'hbb, 32'hcc, 5'd6, 1, 2'd2, 0, 0);
        expect_out("flush_with_en", 0, mk(0, 32'h3024, 0, 0, 0, 0, 0, 0, 0, 0, 5, 3));
        @(negedge clk);
        drv(1, 0, 1, 32'h3028, 32'h6, 32'h60, 32'ha, 5'd31, 1, 2'd1, 0, 0);
        expect_out("load_after_bubbles", 0, mk(1, 32'h3028, 32'h6, 32'h60, 32'ha, 31, 1, 0, 0, 0, 6, 3));

        // Asynchronous reset asserted mid-cycle with arbitrary inputs.
        @(negedge clk);
        #2;
        drv(1, 0, 1, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 1, 2'($urandom),
            5'($urandom), 1'($urandom));
        reset = 1'b0;
        expect_out("async_reset", 0, rst_o);
        expect_out("async_reset", 1, rst_o);
        ->sample_ev;
        @(negedge clk);
        expect_out("reset_held", 0, rst_o);
        @(negedge clk);
        reset = 1'b1;
        drv(1, 0, 1, 32'h3030, 32'h7, 32'h70, 32'hb, 5'd2, 1, 2'd2, 0, 0);
        expect_out("post_reset_load", 0, mk(1, 32'h3030, 32'h7, 32'h70, 32'hb, 2, 1, 1, 0, 0, 1, 0));
        expect_out("post_reset_load", 1, mk(1, 32'h3030, 32'h7, 32'h70, 32'hb, 2, 1, 1, 0, 0, 1, 0));
        @(negedge clk);
        drv(0, 1, 1, 32'h3010, 32'h8, 32'h80, 32'hc, 5'd2, 1, 2'd2, 0, 1);
        expect_out("flush_keep_pc", 0, mk(0, 32'h3010, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        expect_out("flush_zero_pc", 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        @(negedge clk);
        drv(1, 0, 0, 32'h3040, 32'h9, 32'h90, 32'hd, 5'd2, 1, 2'd2, 0, 1);
        expect_out("bubble_keep_pc", 0, mk(0, 32'h3040, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2));
        expect_out("bubble_zero_pc", 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));

        // Saturation on the 4-bit counter build.
        @(negedge clk);
        reset = 1'b0;
        expect_out("sat_reset", 2, rst_o);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            reset = 1'b1;
            drv(1, 0, 1, 32'h3100 + 4 * i, i, i, 0, 5'd1, 1, 2'd0, 0, 0);
            expect_out("sat_inst", 2, mk(1, 32'h3100 + 4 * i, i, i, 0, 1, 1, 0, 0, 0,
                                         (i > 15) ? 16'd15 : 16'(i), 0));
        end
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            drv(1, 0, 0, 32'h3200 + 4 * k, k, k, k, 5'd1, 1, 2'd1, 0, 0);
            expect_out("sat_bubble", 2, mk(0, 32'h3200 + 4 * k, 0, 0, 0, 0, 0, 0, 0, 0, 15,
                                           (k > 15) ? 16'd15 : 16'(k)));
        end

        repeat (3) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
